// File: rtl/flex_serializer_if.sv
// Bundle between the TX register/frame-FSM side (master) and the serializer (slave).
interface flex_serializer_if #(
    parameter int DATA_MAX = 8,
    parameter int CNT_W    = 4
);
    logic                Data_Valid;
    logic [DATA_MAX-1:0] P_DATA;
    logic [CNT_W-1:0]    data_len;
    logic                msb_first;
    logic                ser_en;
    logic                ser_data;
    logic                ser_done;
    logic                par_bit;
    logic                load_ready;
    logic                busy;
    logic                ovf;
    logic                udf;

    modport master (
        output Data_Valid, P_DATA, data_len, msb_first, ser_en,
        input  ser_data, ser_done, par_bit, load_ready, busy, ovf, udf
    );

    modport slave (
        input  Data_Valid, P_DATA, data_len, msb_first, ser_en,
        output ser_data, ser_done, par_bit, load_ready, busy, ovf, udf
    );
endinterface

// File: rtl/flex_serializer.sv
// Double-buffered parallel-to-serial converter: holding register feeds a shifter,
// run-time frame length and bit order, even parity over the active frame.
module flex_serializer #(
    parameter int DATA_MAX = 8,
    parameter int CNT_W    = 4
) (
    input  logic              CLK,
    input  logic              RST,
    flex_serializer_if.slave  bus
);

    logic [DATA_MAX-1:0] hold_q;
    logic [DATA_MAX-1:0] shr_q;
    logic                hold_full_q;
    logic                frame_loaded_q;
    logic                msb_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    len_q;
    logic                ser_data_q;
    logic                ser_done_q;
    logic                par_q;
    logic                ovf_q;
    logic                udf_q;

    logic [CNT_W-1:0]    len_in;
    logic [CNT_W-1:0]    bit_idx;
    logic                shift;
    logic                last_bit;
    logic                transfer;
    logic                accept;
    logic                next_bit;
    logic                hold_par;

    // Out-of-range lengths (0 or above DATA_MAX) fall back to a full-width frame.
    always_comb begin
        len_in = bus.data_len;
        if ((bus.data_len == '0) || (bus.data_len > CNT_W'(DATA_MAX)))
            len_in = CNT_W'(DATA_MAX);
    end

    assign shift    = bus.ser_en && frame_loaded_q;
    assign last_bit = shift && (cnt_q == (len_q - CNT_W'(1)));
    assign transfer = hold_full_q && (!frame_loaded_q || last_bit);
    assign accept   = bus.Data_Valid && !hold_full_q;
    assign bit_idx  = msb_q ? (len_q - CNT_W'(1) - cnt_q) : cnt_q;

    always_comb begin
        next_bit = 1'b0;
        for (int i = 0; i < DATA_MAX; i++)
            if (bit_idx == CNT_W'(i)) next_bit = shr_q[i];
    end

    always_comb begin
        hold_par = 1'b0;
        for (int i = 0; i < DATA_MAX; i++)
            if (CNT_W'(i) < len_in) hold_par = hold_par ^ hold_q[i];
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            hold_q         <= '0;
            shr_q          <= '0;
            hold_full_q    <= 1'b0;
            frame_loaded_q <= 1'b0;
            msb_q          <= 1'b0;
            cnt_q          <= '0;
            len_q          <= '0;
            ser_data_q     <= 1'b0;
            ser_done_q     <= 1'b0;
            par_q          <= 1'b0;
            ovf_q          <= 1'b0;
            udf_q          <= 1'b0;
        end else begin
            // accept and transfer are mutually exclusive: one needs hold empty, the other full.
            if (accept) begin
                hold_q      <= bus.P_DATA;
                hold_full_q <= 1'b1;
            end else if (transfer) begin
                hold_full_q <= 1'b0;
            end

            if (transfer) begin
                shr_q          <= hold_q;
                len_q          <= len_in;
                msb_q          <= bus.msb_first;
                par_q          <= hold_par;
                cnt_q          <= '0;
                frame_loaded_q <= 1'b1;
            end else if (shift) begin
                cnt_q <= cnt_q + CNT_W'(1);
                if (last_bit) frame_loaded_q <= 1'b0;
            end

            ser_data_q <= shift ? next_bit : 1'b0;
            ser_done_q <= last_bit;
            ovf_q      <= bus.Data_Valid && hold_full_q;
            udf_q      <= bus.ser_en && !frame_loaded_q;
        end
    end

    assign bus.ser_data   = ser_data_q;
    assign bus.ser_done   = ser_done_q;
    assign bus.par_bit    = par_q;
    assign bus.load_ready = !hold_full_q;
    assign bus.busy       = frame_loaded_q | hold_full_q;
    assign bus.ovf        = ovf_q;
    assign bus.udf        = udf_q;

endmodule

// File: tb/tb_flex_serializer.sv
// Scoreboard bench for flex_serializer: enabled cycles queue their expected bit,
// an independent monitor pops and compares on each presented output.
module tb_flex_serializer;

    logic clk;
    logic rst_n;

    flex_serializer_if #(.DATA_MAX(8), .CNT_W(4)) bus ();

    flex_serializer #(.DATA_MAX(8), .CNT_W(4)) dut (
        .CLK (clk),
        .RST (rst_n),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic  d;
        logic  done;
        logic  udf;
        logic  par;
        string tag;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    logic en_seen = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a bit is presented on the negedge following each sampled ser_en.
    always @(posedge clk) en_seen <= bus.ser_en;

    always @(negedge clk) begin
        if (en_seen) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL sb_empty: got output with no expected entry at %0t", $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.tag, "_data"}, 32'(bus.ser_data), 32'(e.d));
                chk({e.tag, "_done"}, 32'(bus.ser_done), 32'(e.done));
                chk({e.tag, "_udf"},  32'(bus.udf),      32'(e.udf));
                chk({e.tag, "_par"},  32'(bus.par_bit),  32'(e.par));
            end
        end
    end

    task automatic push_one(input string tag, input logic d, input logic done,
                            input logic udf, input logic par);
        exp_t e;
        e.d = d; e.done = done; e.udf = udf; e.par = par; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic load(input logic [7:0] w, input logic [3:0] len, input logic msb);
        bus.Data_Valid = 1'b1;
        bus.P_DATA     = w;
        bus.data_len   = len;
        bus.msb_first  = msb;
        @(negedge clk);
        bus.Data_Valid = 1'b0;
    endtask

    // Continuous ser_en for bits.len() cycles; optional load of w at cycle load_at.
    task automatic run_en(input string tag, input string bits, input string dones,
                          input string pars, input int load_at, input logic [7:0] w);
        for (int i = 0; i < bits.len(); i++)
            push_one(tag, bits[i] == "1", dones[i] == "1", 1'b0, pars[i] == "1");
        for (int i = 0; i < bits.len(); i++) begin
            if (i == load_at) begin
                bus.Data_Valid = 1'b1;
                bus.P_DATA     = w;
            end else begin
                bus.Data_Valid = 1'b0;
            end
            bus.ser_en = 1'b1;
            @(negedge clk);
        end
        bus.ser_en     = 1'b0;
        bus.Data_Valid = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_load_ready"}, 32'(bus.load_ready), 32'd1);
        chk({tag, "_busy"},       32'(bus.busy),       32'd0);
        chk({tag, "_ser_data"},   32'(bus.ser_data),   32'd0);
        chk({tag, "_ser_done"},   32'(bus.ser_done),   32'd0);
        chk({tag, "_par_bit"},    32'(bus.par_bit),    32'd0);
        chk({tag, "_ovf"},        32'(bus.ovf),        32'd0);
        chk({tag, "_udf"},        32'(bus.udf),        32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        string gap_bits;
        rst_n          = 1'b0;
        bus.Data_Valid = 1'b0;
        bus.P_DATA     = '0;
        bus.data_len   = 4'd8;
        bus.msb_first  = 1'b0;
        bus.ser_en     = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_outputs("rst");

        // LSB first, 0xA5, with load/transfer timing
        load(8'hA5, 4'd8, 1'b0);
        chk("lsb8_lr_after_load", 32'(bus.load_ready), 32'd0);
        chk("lsb8_busy_after_load", 32'(bus.busy), 32'd1);
        @(negedge clk);
        chk("lsb8_lr_after_xfer", 32'(bus.load_ready), 32'd1);
        chk("lsb8_busy_after_xfer", 32'(bus.busy), 32'd1);
        run_en("lsb8", "10100101", "00000001", "00000000", -1, 8'h00);

        // MSB first, 5-bit frame of 0xF3
        load(8'hF3, 4'd5, 1'b1);
        @(negedge clk);
        run_en("msb5", "10011", "00001", "11111", -1, 8'h00);

        // data_len=0 clamps to 8 bits
        load(8'h01, 4'd0, 1'b1);
        @(negedge clk);
        run_en("len0", "00000001", "00000001", "11111111", -1, 8'h00);

        // back-to-back: 0x81 loaded while 0x0F shifts
        load(8'h0F, 4'd8, 1'b0);
        @(negedge clk);
        run_en("b2b", "1111000010000001", "0000000100000001", "0000000000000000", 1, 8'h81);
        chk("b2b_busy_end", 32'(bus.busy), 32'd0);
        chk("b2b_lr_end", 32'(bus.load_ready), 32'd1);

        // gapped enable on 0x3C
        gap_bits = "00111100";
        load(8'h3C, 4'd8, 1'b0);
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            push_one("gap", gap_bits[i] == "1", i == 7, 1'b0, 1'b0);
            bus.ser_en = 1'b1;
            @(negedge clk);
            bus.ser_en = 1'b0;
            @(negedge clk);
            chk("gap_idle_data", 32'(bus.ser_data), 32'd0);
            chk("gap_idle_done", 32'(bus.ser_done), 32'd0);
        end

        // underflow with empty shifter
        push_one("udf", 1'b0, 1'b0, 1'b1, 1'b0);
        bus.ser_en = 1'b1;
        @(negedge clk);
        bus.ser_en = 1'b0;
        @(negedge clk);
        chk("udf_one_cycle", 32'(bus.udf), 32'd0);

        // overflow: third word dropped, held word survives
        load(8'h01, 4'd8, 1'b0);
        @(negedge clk);
        bus.Data_Valid = 1'b1;
        bus.P_DATA     = 8'hC3;
        @(negedge clk);
        bus.P_DATA     = 8'h7E;
        @(negedge clk);
        bus.Data_Valid = 1'b0;
        chk("ovf_pulse", 32'(bus.ovf), 32'd1);
        chk("ovf_lr", 32'(bus.load_ready), 32'd0);
        @(negedge clk);
        chk("ovf_one_cycle", 32'(bus.ovf), 32'd0);
        run_en("ovf", "1000000011000011", "0000000100000001", "1111111000000000", -1, 8'h00);

        // reset mid-frame after 3 bits of 0x07
        load(8'h07, 4'd8, 1'b0);
        @(negedge clk);
        run_en("midrst", "111", "000", "111", -1, 8'h00);
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset_outputs("midrst");
        rst_n = 1'b1;
        @(negedge clk);
        push_one("postrst_udf", 1'b0, 1'b0, 1'b1, 1'b0);
        bus.ser_en = 1'b1;
        @(negedge clk);
        bus.ser_en = 1'b0;
        repeat (2) @(negedge clk);

        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
